// File: rtl/scan_if.sv
// scan_if: control inputs and decoder-side outputs of the scan sequencer.
interface scan_if #(parameter int DIV_W = 16);
  logic             en;
  logic             oneshot;
  logic [7:0]       mask;
  logic [DIV_W-1:0] div;
  logic [2:0]       a;
  logic             sta;
  logic             stb;
  logic             stc;
  logic             busy;
  logic             frame_done;
  modport master (output en, oneshot, mask, div, input a, sta, stb, stc, busy, frame_done);
  modport slave  (input en, oneshot, mask, div, output a, sta, stb, stc, busy, frame_done);
endinterface

// File: rtl/scan_sequencer.sv
// scan_sequencer: steps a 3-to-8 decoder select through masked channels with dwell and blanking.
module scan_sequencer #(
  parameter int DIV_W = 16,
  parameter int BLANK = 2
) (
  input logic clk,
  input logic rst_n,
  scan_if.slave s
);
  typedef enum logic [1:0] {IDLE, DWELL, GAP} state_t;
  localparam logic [7:0] GL = 8'(BLANK > 0 ? BLANK - 1 : 0);
  state_t state, nstate;
  logic [DIV_W-1:0] cnt, ncnt;
  logic [7:0] gcnt, ngcnt;
  logic [2:0] na, pend, npend, nxt, low, ch;
  logic pwrap, npwrap, hold, nhold, done, adv, wrf, live, busy;
  always_comb begin
    nxt = s.a;
    low = 3'd0;
    for (int i = 7; i >= 1; i--) if (s.mask[3'(s.a + 3'(i))]) nxt = 3'(s.a + 3'(i));
    for (int i = 7; i >= 0; i--) if (s.mask[i]) low = 3'(i);
  end
  // with no gap the hop uses the live lookup; otherwise the choice latched at the advance point
  assign ch  = (BLANK == 0) ? nxt : pend;
  assign wrf = (BLANK == 0) ? (nxt <= s.a) : pwrap;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      gcnt <= '0;
      pend <= '0;
      pwrap <= 1'b0;
      hold <= 1'b0;
      s.a <= '0;
      s.sta <= 1'b0;
      s.stb <= 1'b1;
      s.stc <= 1'b1;
      s.busy <= 1'b0;
      s.frame_done <= 1'b0;
    end else begin
      state <= nstate;
      cnt <= ncnt;
      gcnt <= ngcnt;
      pend <= npend;
      pwrap <= npwrap;
      hold <= nhold;
      s.a <= na;
      s.sta <= live;
      s.stb <= ~live;
      s.stc <= ~live;
      s.busy <= busy;
      s.frame_done <= done;
    end
  always_comb begin
    nstate = state;
    ncnt = cnt;
    ngcnt = gcnt;
    na = s.a;
    npend = pend;
    npwrap = pwrap;
    nhold = hold & s.en;
    done = 1'b0;
    adv = 1'b0;
    case (state)
      IDLE:
        if (s.en && s.mask != 8'd0 && !hold) begin
          nstate = DWELL;
          na = low;
          ncnt = s.div;
        end
      DWELL:
        if (!s.en) begin
          nstate = IDLE;
          ncnt = '0;
          ngcnt = '0;
        end else if (cnt != '0) ncnt = cnt - DIV_W'(1);
        else if (s.mask == 8'd0) nstate = IDLE;
        else if (BLANK == 0) adv = 1'b1;
        else begin
          nstate = GAP;
          ngcnt = GL;
          npend = nxt;
          npwrap = nxt <= s.a;
        end
      GAP:
        if (!s.en) begin
          nstate = IDLE;
          ncnt = '0;
          ngcnt = '0;
        end else if (gcnt != 8'd0) ngcnt = gcnt - 8'd1;
        else adv = 1'b1;
      default: nstate = IDLE;
    endcase
    if (adv) begin
      done = wrf;
      if (wrf && s.oneshot) begin
        nstate = IDLE;
        nhold = 1'b1;
      end else begin
        nstate = DWELL;
        na = ch;
        ncnt = s.div;
      end
    end
  end
  always_comb begin
    live = nstate == DWELL;
    busy = nstate != IDLE;
  end
endmodule
